// File: rtl/axi_lite_intr_ctrl.sv
// AXI4-Lite interrupt controller: GIE/IER/ISR/IAR/IPR registers, one irq line.
// Define INTR_SRC_EDGE_EN for rising-edge sources; default is level-sensitive.
module axi_lite_intr_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_OF_INTR      = 1,
  parameter int C_IRQ_ACTIVE_HIGH  = 1
) (
  input  logic                            s_axi_intr_aclk,
  input  logic                            s_axi_intr_aresetn,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_intr_awaddr,
  input  logic [2:0]                      s_axi_intr_awprot,
  input  logic                            s_axi_intr_awvalid,
  output logic                            s_axi_intr_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_intr_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_intr_wstrb,
  input  logic                            s_axi_intr_wvalid,
  output logic                            s_axi_intr_wready,
  output logic [1:0]                      s_axi_intr_bresp,
  output logic                            s_axi_intr_bvalid,
  input  logic                            s_axi_intr_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_intr_araddr,
  input  logic [2:0]                      s_axi_intr_arprot,
  input  logic                            s_axi_intr_arvalid,
  output logic                            s_axi_intr_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_intr_rdata,
  output logic [1:0]                      s_axi_intr_rresp,
  output logic                            s_axi_intr_rvalid,
  input  logic                            s_axi_intr_rready,
  output logic                            irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int N  = C_NUM_OF_INTR;
  localparam logic IRQ_OFF = (C_IRQ_ACTIVE_HIGH == 0);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic          w_wr_hs, w_rd_hs;
  logic [2:0]    w_waddr, w_raddr;
  logic [DW-1:0] w_wmask, w_wd, w_rmux;
  logic          w_rerr;
  logic [N-1:0]  w_event, w_iar_clr;
  logic          w_irq_int;
  logic          w_unused;

  logic          r_gie;
  logic [N-1:0]  r_ier, r_isr;
  logic [1:0]    r_bresp, r_rresp;
  logic [DW-1:0] r_rdata;
  logic          r_irq;

  assign w_waddr = s_axi_intr_awaddr[4:2];
  assign w_raddr = s_axi_intr_araddr[4:2];
  assign w_unused = ^{s_axi_intr_awprot, s_axi_intr_arprot,
                      s_axi_intr_awaddr[1:0], s_axi_intr_araddr[1:0],
                      s_axi_intr_wdata};

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_hs      = 1'b0;
    case (r_wstate)
      W_IDLE: if (s_axi_intr_awvalid && s_axi_intr_wvalid) begin
        w_wr_hs      = 1'b1;
        w_wstate_nxt = W_RESP;
      end
      W_RESP: if (s_axi_intr_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_hs      = 1'b0;
    case (r_rstate)
      R_IDLE: if (s_axi_intr_arvalid) begin
        w_rd_hs      = 1'b1;
        w_rstate_nxt = R_DATA;
      end
      R_DATA: if (s_axi_intr_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    for (int b = 0; b < DW/8; b++)
      w_wmask[8*b +: 8] = {8{s_axi_intr_wstrb[b]}};
  end
  assign w_wd = s_axi_intr_wdata & w_wmask;

  assign w_iar_clr = (w_wr_hs && w_waddr == 3'd3) ? w_wd[N-1:0] : '0;

`ifdef INTR_SRC_EDGE_EN
  logic [N-1:0] r_src_q;
  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) r_src_q <= '0;
    else                     r_src_q <= intr_src;
  end
  assign w_event = intr_src & ~r_src_q;
`else
  assign w_event = intr_src;
`endif

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      r_gie   <= 1'b0;
      r_ier   <= '0;
      r_bresp <= 2'b00;
    end else if (w_wr_hs) begin
      if (w_waddr == 3'd0 && s_axi_intr_wstrb[0])
        r_gie <= s_axi_intr_wdata[0];
      if (w_waddr == 3'd1)
        r_ier <= (r_ier & ~w_wmask[N-1:0]) | w_wd[N-1:0];
      r_bresp <= (w_waddr > 3'd4) ? 2'b10 : 2'b00;
    end
  end

  // A new event beats a same-cycle acknowledge so no event is lost.
  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) r_isr <= '0;
    else                     r_isr <= (r_isr & ~w_iar_clr) | w_event;
  end

  always_comb begin
    w_rmux = '0;
    w_rerr = 1'b0;
    case (w_raddr)
      3'd0:    w_rmux[0]     = r_gie;
      3'd1:    w_rmux[N-1:0] = r_ier;
      3'd2:    w_rmux[N-1:0] = r_isr;
      3'd3:    w_rmux        = '0;
      3'd4:    w_rmux[N-1:0] = r_isr & r_ier;
      default: w_rerr        = 1'b1;
    endcase
  end

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else if (w_rd_hs) begin
      r_rdata <= w_rmux;
      r_rresp <= w_rerr ? 2'b10 : 2'b00;
    end
  end

  assign w_irq_int = r_gie & (|(r_isr & r_ier));

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) r_irq <= IRQ_OFF;
    else                     r_irq <= w_irq_int ^ IRQ_OFF;
  end

  assign s_axi_intr_awready = w_wr_hs;
  assign s_axi_intr_wready  = w_wr_hs;
  assign s_axi_intr_bvalid  = (r_wstate == W_RESP);
  assign s_axi_intr_bresp   = r_bresp;
  assign s_axi_intr_arready = w_rd_hs;
  assign s_axi_intr_rvalid  = (r_rstate == R_DATA);
  assign s_axi_intr_rdata   = r_rdata;
  assign s_axi_intr_rresp   = r_rresp;
  assign irq                = r_irq;

endmodule

// File: tb/tb_axi_lite_intr_ctrl.sv
// Bench for axi_lite_intr_ctrl: directed scenarios plus random traffic
// checked cycle by cycle against a register-map reference model.
module tb_axi_lite_intr_ctrl;
  localparam int N = 1;
  localparam int POL = 1;
  localparam logic ACT = (POL != 0);
  localparam logic INACT = ~ACT;
`ifdef INTR_SRC_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] intr_src;
  logic [4:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic irq;

  always #5 clk = ~clk;

  axi_lite_intr_ctrl #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5),
    .C_NUM_OF_INTR(N), .C_IRQ_ACTIVE_HIGH(POL)
  ) dut (
    .s_axi_intr_aclk(clk), .s_axi_intr_aresetn(rst_n),
    .intr_src(intr_src),
    .s_axi_intr_awaddr(awaddr), .s_axi_intr_awprot(awprot),
    .s_axi_intr_awvalid(awvalid), .s_axi_intr_awready(awready),
    .s_axi_intr_wdata(wdata), .s_axi_intr_wstrb(wstrb),
    .s_axi_intr_wvalid(wvalid), .s_axi_intr_wready(wready),
    .s_axi_intr_bresp(bresp), .s_axi_intr_bvalid(bvalid),
    .s_axi_intr_bready(bready),
    .s_axi_intr_araddr(araddr), .s_axi_intr_arprot(arprot),
    .s_axi_intr_arvalid(arvalid), .s_axi_intr_arready(arready),
    .s_axi_intr_rdata(rdata), .s_axi_intr_rresp(rresp),
    .s_axi_intr_rvalid(rvalid), .s_axi_intr_rready(rready),
    .irq(irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit m_gie;
  bit [N-1:0] m_ier, m_isr, m_prev;
  bit m_bv, m_rv;
  bit [1:0] m_br, m_rr;
  bit [31:0] m_rd;
  logic m_irq;
  bit hs_w, hs_r;

  task automatic model_reset();
    m_gie = 0; m_ier = '0; m_isr = '0; m_prev = '0;
    m_bv = 0; m_rv = 0; m_br = 0; m_rr = 0; m_rd = 0;
    m_irq = INACT; hs_w = 0; hs_r = 0;
  endtask

  function automatic logic [31:0] reg_val(input logic [2:0] idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      3'd0: v[0] = m_gie;
      3'd1: v[N-1:0] = m_ier;
      3'd2: v[N-1:0] = m_isr;
      3'd4: v[N-1:0] = m_isr & m_ier;
      default: v = '0;
    endcase
    return v;
  endfunction

  // One clock: predict effect of the coming edge, then compare after it.
  task automatic cyc();
    bit [N-1:0] ev, clr;
    bit [31:0] msk, wd;
    logic nirq;
    @(negedge clk);
    hs_w = !m_bv && awvalid && wvalid;
    hs_r = !m_rv && arvalid;
    chk("awready", awready, hs_w);
    chk("wready", wready, hs_w);
    chk("arready", arready, hs_r);
    ev = EDGE ? (intr_src & ~m_prev) : intr_src;
    nirq = (m_gie && |(m_isr & m_ier)) ? ACT : INACT;
    if (hs_r) begin
      m_rd = reg_val(araddr[4:2]);
      m_rr = (araddr[4:2] > 3'd4) ? 2'b10 : 2'b00;
      m_rv = 1;
    end else if (m_rv && rready) m_rv = 0;
    clr = '0;
    if (hs_w) begin
      for (int b = 0; b < 4; b++) msk[8*b +: 8] = {8{wstrb[b]}};
      wd = wdata & msk;
      case (awaddr[4:2])
        3'd0: if (wstrb[0]) m_gie = wdata[0];
        3'd1: m_ier = (m_ier & ~msk[N-1:0]) | wd[N-1:0];
        3'd3: clr = wd[N-1:0];
        default: ;
      endcase
      m_br = (awaddr[4:2] > 3'd4) ? 2'b10 : 2'b00;
      m_bv = 1;
    end else if (m_bv && bready) m_bv = 0;
    m_isr = (m_isr & ~clr) | ev;
    m_prev = intr_src;
    m_irq = nirq;
    @(posedge clk); #1;
    chk("irq", irq, m_irq);
    chk("bvalid", bvalid, m_bv);
    chk("rvalid", rvalid, m_rv);
    if (m_bv) chk("bresp", bresp, m_br);
    if (m_rv) begin
      chk("rdata", rdata, m_rd);
      chk("rresp", rresp, m_rr);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    n = 0;
    do begin cyc(); n++; end while (!hs_w && n < 20);
    if (!hs_w) chk("wr_timeout", 0, 1);
    awvalid = 0; wvalid = 0;
    resp = bresp;
    n = 0;
    while (m_bv && n < 20) begin cyc(); n++; end
    if (m_bv) chk("b_timeout", 0, 1);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d,
                    output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1;
    n = 0;
    do begin cyc(); n++; end while (!hs_r && n < 20);
    if (!hs_r) chk("rd_timeout", 0, 1);
    arvalid = 0;
    d = rdata; resp = rresp;
    n = 0;
    while (m_rv && n < 20) begin cyc(); n++; end
    if (m_rv) chk("r_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=%0d exp=finish", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0] rsp;
    rst_n = 0; intr_src = '0;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    araddr = 0; arprot = 0; arvalid = 0; bready = 1; rready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", irq, INACT);
    rst_n = 1;

    wr(5'h00, 32'h0101FFFF, 4'hF, rsp); chk("gie_bresp", rsp, 0);
    wr(5'h04, 32'h0101FFFF, 4'hF, rsp); chk("ier_bresp", rsp, 0);
    rd(5'h00, d, rsp); chk("gie_rb", d, 1); chk("gie_rresp", rsp, 0);
    rd(5'h04, d, rsp); chk("ier_rb", d, 1);

    intr_src = 1; cyc();
    intr_src = 0; chk("irq_lat_n", irq, INACT);
    cyc(); chk("irq_lat_n1", irq, ACT);
    rd(5'h10, d, rsp); chk("ipr_set", d, 1);
    wr(5'h0C, 32'h1, 4'hF, rsp); chk("irq_ack", irq, INACT);
    rd(5'h10, d, rsp); chk("ipr_clr", d, 0);

    wr(5'h00, 32'h0, 4'hF, rsp);
    intr_src = 1; cyc(); intr_src = 0; cyc(); cyc();
    chk("irq_gie0", irq, INACT);
    rd(5'h08, d, rsp); chk("isr_gie0", d, 1);
    wr(5'h00, 32'h1, 4'hF, rsp); chk("irq_gie1", irq, ACT);

    intr_src = 1; awaddr = 5'h0C; wdata = 1; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    cyc(); chk("set_ack_hs", hs_w, 1);
    intr_src = 0; awvalid = 0; wvalid = 0;
    cyc(); cyc();
    rd(5'h08, d, rsp); chk("set_wins", d, 1);
    chk("set_wins_irq", irq, ACT);

    rd(5'h14, d, rsp); chk("unm_rdata", d, 0); chk("unm_rresp", rsp, 2);
    wr(5'h18, 32'hFFFFFFFF, 4'hF, rsp); chk("unm_bresp", rsp, 2);
    rd(5'h00, d, rsp); chk("unm_gie", d, 1);
    rd(5'h04, d, rsp); chk("unm_ier", d, 1);

    bready = 0; rready = 0;
    awaddr = 5'h1C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 5'h08; arvalid = 1;
    cyc(); awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (5) cyc();
    chk("hold_bvalid", bvalid, 1);
    chk("hold_rvalid", rvalid, 1);
    chk("hold_rdata", rdata, 1);
    bready = 1; rready = 1; cyc();

    bready = 0;
    awaddr = 5'h1C; awvalid = 1; wvalid = 1;
    cyc(); awvalid = 0; wvalid = 0;
    chk("pre_rst_bv", bvalid, 1);
    chk("pre_rst_irq", irq, ACT);
    rst_n = 0; #1;
    chk("mid_rst_bv", bvalid, 0);
    chk("mid_rst_irq", irq, INACT);
    model_reset();
    repeat (2) @(posedge clk);
    #1; rst_n = 1; bready = 1;
    rd(5'h00, d, rsp); chk("post_gie", d, 0);
    rd(5'h04, d, rsp); chk("post_ier", d, 0);
    rd(5'h08, d, rsp); chk("post_isr", d, 0);
    rd(5'h10, d, rsp); chk("post_ipr", d, 0);

    intr_src = 1;
    wr(5'h04, 32'h1, 4'hF, rsp);
    wr(5'h0C, 32'h1, 4'hF, rsp);
    cyc(); cyc();
    rd(5'h08, d, rsp); chk("held_src_ack", d, EDGE ? 0 : 1);
    intr_src = 0;

    for (int i = 0; i < 2500; i++) begin
      intr_src = ($urandom_range(3) == 0) ? N'($urandom) : '0;
      bready = ($urandom_range(3) != 0);
      rready = ($urandom_range(3) != 0);
      if (hs_w) begin awvalid = 0; wvalid = 0; end
      if (hs_r) arvalid = 0;
      if (!awvalid && !wvalid) begin
        if ($urandom_range(3) == 0) begin
          awaddr = 5'($urandom);
          wdata = $urandom;
          wstrb = 4'($urandom);
          awvalid = 1'($urandom);
          wvalid = 1'($urandom);
          if (!awvalid && !wvalid) begin awvalid = 1; wvalid = 1; end
        end
      end else if ($urandom_range(1) == 0) begin
        awvalid = 1; wvalid = 1;
      end
      if (!arvalid && $urandom_range(3) == 0) begin
        araddr = 5'($urandom);
        arvalid = 1;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
